// File: rtl/line_kernel_buffer.sv
// line_kernel_buffer: turns a raster pixel stream into 3x3 neighbourhood windows using two rotating line RAMs.
module line_kernel_buffer #(
    parameter int PIXEL_W   = 24,
    parameter int H_RES     = 320,
    parameter int V_RES     = 240,
    parameter bit EDGE_MODE = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [PIXEL_W-1:0]         pixel_in,
    input  logic                       pixel_valid,
    input  logic                       frame_start,
    output logic                       in_ready,
    output logic [9*PIXEL_W-1:0]       kernel_out,
    output logic                       kernel_valid,
    output logic [$clog2(V_RES)-1:0]   kernel_row,
    output logic [$clog2(H_RES)-1:0]   kernel_col
);
    localparam int CW = $clog2(H_RES + 1);
    localparam int KC = $clog2(H_RES);
    localparam int KR = $clog2(V_RES);
    localparam logic [CW-1:0] C_LAST = CW'(H_RES - 1);
    localparam logic [CW-1:0] C_GAP  = CW'(H_RES);
    localparam logic [KR-1:0] R_LAST = KR'(V_RES - 1);

    typedef enum logic [2:0] {IDLE, FILL, STREAM, GAP, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [KR-1:0]       row_q, row_d;
    logic [CW-1:0]       col_q, col_d;
    logic                ptr_q, ptr_d;
    logic                acc, start, abort, beat, wr, wsel;
    logic [CW-1:0]       beat_col;
    logic [KR-1:0]       beat_krow;
    logic [KC-1:0]       waddr, raddr;
    logic [PIXEL_W-1:0]  mem_q [2][H_RES];
    logic [PIXEL_W-1:0]  rd_q [2];
    logic                s1_v_q, s1_top_q, s1_bot_q, s1_sel_q;
    logic [CW-1:0]       s1_col_q;
    logic [KR-1:0]       s1_krow_q;
    logic [PIXEL_W-1:0]  s1_pix_q;
    logic [PIXEL_W-1:0]  nc [3];
    logic [PIXEL_W-1:0]  w0_q [3];
    logic [PIXEL_W-1:0]  w1_q [3];
    logic [9*PIXEL_W-1:0] kern_d;
    logic                kv_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        ptr_d   = ptr_q;
        if (start) begin
            state_d = FILL;
            row_d   = '0;
            col_d   = CW'(1);
            ptr_d   = 1'b0;
        end else begin
            case (state_q)
                FILL, STREAM: if (acc) begin
                    if (col_q == C_LAST) begin
                        state_d = state_q == FILL ? STREAM : GAP;
                        row_d   = state_q == FILL ? KR'(1) : row_q;
                        col_d   = '0;
                        ptr_d   = ~ptr_q;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                GAP: begin
                    state_d = row_q == R_LAST ? FLUSH : STREAM;
                    row_d   = row_q == R_LAST ? '0 : row_q + 1'b1;
                end
                FLUSH: begin
                    state_d = col_q == C_GAP ? IDLE : FLUSH;
                    col_d   = col_q == C_GAP ? '0 : col_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Beats: accepted row>=1 pixels, the GAP cycle (right edge), and FLUSH cycles (virtual bottom row).
    always_comb begin
        in_ready  = state_q == IDLE || state_q == FILL || state_q == STREAM;
        acc       = pixel_valid && in_ready;
        start     = acc && frame_start;
        abort     = start && state_q != IDLE;
        beat      = (state_q == STREAM && acc && !frame_start) || state_q == GAP || state_q == FLUSH;
        beat_col  = state_q == GAP ? C_GAP : col_q;
        beat_krow = state_q == FLUSH ? R_LAST : row_q - 1'b1;
        wr        = acc && (start || state_q != IDLE);
        wsel      = start ? 1'b0 : ptr_q;
        waddr     = start ? '0 : col_q[KC-1:0];
        raddr     = col_q == C_GAP ? '0 : col_q[KC-1:0];
    end

    // Read-first: the oldest row is read at the same address the new row overwrites.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wsel][waddr] <= pixel_in;
        rd_q[0] <= mem_q[0][raddr];
        rd_q[1] <= mem_q[1][raddr];
    end

    always_ff @(posedge clk) begin
        s1_col_q  <= beat_col;
        s1_krow_q <= beat_krow;
        s1_top_q  <= row_q == KR'(1);
        s1_bot_q  <= state_q == FLUSH;
        s1_sel_q  <= ptr_q;
        s1_pix_q  <= pixel_in;
        if (s1_v_q) begin
            w0_q <= w1_q;
            w1_q <= nc;
        end
    end

    always_comb begin
        nc[1] = rd_q[~s1_sel_q];
        nc[0] = s1_top_q ? (EDGE_MODE ? '0 : nc[1]) : rd_q[s1_sel_q];
        nc[2] = s1_bot_q ? (EDGE_MODE ? '0 : nc[1]) : s1_pix_q;
        kv_d  = s1_v_q && s1_col_q != '0 && !abort;
        for (int i = 0; i < 3; i++) begin
            kern_d[3*i*PIXEL_W +: PIXEL_W]     = s1_col_q == CW'(1) ? (EDGE_MODE ? '0 : w1_q[i]) : w0_q[i];
            kern_d[(3*i+1)*PIXEL_W +: PIXEL_W] = w1_q[i];
            kern_d[(3*i+2)*PIXEL_W +: PIXEL_W] = s1_col_q == C_GAP ? (EDGE_MODE ? '0 : w1_q[i]) : nc[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q       <= 1'b0;
            kernel_valid <= 1'b0;
            kernel_out   <= '0;
            kernel_row   <= '0;
            kernel_col   <= '0;
        end else begin
            s1_v_q       <= beat;
            kernel_valid <= kv_d;
            if (kv_d) begin
                kernel_out <= kern_d;
                kernel_row <= s1_krow_q;
                kernel_col <= KC'(s1_col_q - 1'b1);
            end
        end
    end
endmodule

// File: tb/tb_line_kernel_buffer.sv
// tb_line_kernel_buffer: directed frames into EDGE_MODE 0 and 1 instances, H_RES=4, V_RES=3, pixel = 4r+c.
module tb_line_kernel_buffer;
    localparam int H = 4;
    localparam int V = 3;

    typedef struct {int due; int r; int c;} exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pixel_in = '0;
    logic        pixel_valid = 1'b0;
    logic        frame_start = 1'b0;
    logic        rdy [2];
    logic        kv [2];
    logic [71:0] ko [2];
    logic [1:0]  kr [2];
    logic [1:0]  kc [2];
    logic [71:0] k00 [2];
    logic [71:0] k23 [2];
    logic [71:0] k11 [2];
    exp_t        q [$];
    int          cyc = 0;
    int          nk = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    line_kernel_buffer #(.PIXEL_W(8), .H_RES(H), .V_RES(V), .EDGE_MODE(1'b0)) u0 (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .frame_start(frame_start), .in_ready(rdy[0]), .kernel_out(ko[0]),
        .kernel_valid(kv[0]), .kernel_row(kr[0]), .kernel_col(kc[0]));

    line_kernel_buffer #(.PIXEL_W(8), .H_RES(H), .V_RES(V), .EDGE_MODE(1'b1)) u1 (
        .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .frame_start(frame_start), .in_ready(rdy[1]), .kernel_out(ko[1]),
        .kernel_valid(kv[1]), .kernel_row(kr[1]), .kernel_col(kc[1]));

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tap(input int m, input int r, input int c);
        if (m == 1 && (r < 0 || r >= V || c < 0 || c >= H)) return 8'd0;
        r = r < 0 ? 0 : (r >= V ? V - 1 : r);
        c = c < 0 ? 0 : (c >= H ? H - 1 : c);
        return 8'(4 * r + c);
    endfunction

    function automatic logic [71:0] kern(input int m, input int r, input int c);
        logic [71:0] k;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                k[(3*dr+dc)*8 +: 8] = tap(m, r - 1 + dr, c - 1 + dc);
        return k;
    endfunction

    task automatic tick();
        logic due;
        @(posedge clk);
        #1;
        cyc++;
        due = q.size() > 0 && q[0].due == cyc;
        for (int m = 0; m < 2; m++) begin
            chk("kernel_valid", 72'(kv[m]), 72'(due));
            if (due) begin
                chk("kernel_row", 72'(kr[m]), 72'(q[0].r));
                chk("kernel_col", 72'(kc[m]), 72'(q[0].c));
                chk(m == 0 ? "kernel_out_m0" : "kernel_out_m1", ko[m], kern(m, q[0].r, q[0].c));
                if (q[0].r == 0 && q[0].c == 0) k00[m] = ko[m];
                if (q[0].r == 2 && q[0].c == 3) k23[m] = ko[m];
                if (q[0].r == 1 && q[0].c == 1) k11[m] = ko[m];
            end
        end
        if (due) begin
            nk++;
            void'(q.pop_front());
        end
    endtask

    task automatic cycle(input logic v, input logic fs, input logic [7:0] pix, input int rd, input int br, input int bc);
        pixel_valid = v;
        frame_start = fs;
        pixel_in    = pix;
        if (rd >= 0) begin
            chk("in_ready_m0", 72'(rdy[0]), 72'(rd));
            chk("in_ready_m1", 72'(rdy[1]), 72'(rd));
        end
        if (br >= 0) q.push_back('{cyc + 2, br, bc});
        tick();
    endtask

    // Sends one frame; stops before pixel (ar,ac) if given, runs fl flush cycles.
    task automatic frame(input logic tog, input int ar, input int ac, input int fl);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                if (r == ar && c == ac) return;
                if (tog) cycle(1'b0, 1'b1, 8'hEE, 1, -1, 0);
                cycle(1'b1, r == 0 && c == 0, 8'(4 * r + c), 1, (r >= 1 && c >= 1) ? r - 1 : -1, c - 1);
            end
            if (r >= 1) cycle(!tog, !tog, 8'hEE, 0, r - 1, H - 1);
        end
        for (int c = 0; c < fl; c++) cycle(!tog, !tog, 8'hEE, 0, c >= 1 ? V - 1 : -1, c - 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'h00, 1, -1, 0);
    endtask

    initial begin
        tick();
        tick();
        for (int m = 0; m < 2; m++) begin
            chk("reset_in_ready", 72'(rdy[m]), 72'(1));
            chk("reset_kernel_out", ko[m], 72'(0));
            chk("reset_kernel_row", 72'(kr[m]), 72'(0));
            chk("reset_kernel_col", 72'(kc[m]), 72'(0));
        end
        reset = 1'b0;
        cycle(1'b1, 1'b0, 8'h55, 1, -1, 0);
        frame(1'b0, -1, -1, H + 1);
        drain();
        chk("continuous_count", 72'(nk), 72'(12));
        chk("m0_centre_0_0", k00[0], {8'd5, 8'd4, 8'd4, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0});
        chk("m0_centre_2_3", k23[0], {8'd11, 8'd11, 8'd10, 8'd11, 8'd11, 8'd10, 8'd7, 8'd7, 8'd6});
        chk("m1_centre_0_0", k00[1], {8'd5, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
        chk("m1_centre_1_1", k11[1], {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0});
        chk("m1_centre_2_3", k23[1], {8'd0, 8'd0, 8'd0, 8'd0, 8'd11, 8'd10, 8'd0, 8'd7, 8'd6});
        nk = 0;
        frame(1'b1, -1, -1, H + 1);
        drain();
        chk("toggled_count", 72'(nk), 72'(12));
        nk = 0;
        frame(1'b0, 1, 2, H + 1);
        q.delete();
        frame(1'b0, -1, -1, H + 1);
        drain();
        chk("abort_count", 72'(nk), 72'(12));
        frame(1'b0, -1, -1, 2);
        q.delete();
        reset = 1'b1;
        cycle(1'b0, 1'b0, 8'h00, -1, -1, 0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'(i), 1, -1, 0);
        nk = 0;
        frame(1'b0, -1, -1, H + 1);
        frame(1'b0, -1, -1, H + 1);
        drain();
        chk("back_to_back_count", 72'(nk), 72'(24));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
